// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load path: RISC-V load funct3
// codes, the load-unit FSM encoding and request classification helpers.
package dmem_pkg;

  // RISC-V load funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Width of the RAM latency down-counter; holds READ_LATENCY-1 (0..3)
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // funct3 values that do not name a load (011, 110, 111)
  function automatic logic is_illegal_funct3(input logic [2:0] funct3);
    return !(funct3 inside {LB, LH, LW, LBU, LHU});
  endfunction

  // Halfword on an odd byte, or word not on a 4-byte boundary
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] offset);
    case (funct3)
      LH, LHU: return offset[0];
      LW:      return offset != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Combinational load extractor: picks the byte/halfword/word addressed by
// offset out of a RAM word and sign- or zero-extends it to 32 bits.
// Halfword selection uses offset[1] only, word loads ignore the offset.
module load_align_ext
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{offset, 3'b000} +: 8];
  assign half_sel = offset[1] ? word[31:16] : word[15:0];

  // Extend the selected field according to the load type
  always_comb begin
    // NOTE: default first so every path assigns result; otherwise a latch is inferred.
    result = '0;
    case (funct3)
      LB:      result = {{24{byte_sel[7]}}, byte_sel};
      LBU:     result = {24'h0, byte_sel};
      LH:      result = {{16{half_sel[15]}}, half_sel};
      LHU:     result = {16'h0, half_sel};
      LW:      result = word;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/dmem_load_unit.sv
// Data-memory load unit: accepts one load at a time, issues a single word
// read to the synchronous data RAM, waits READ_LATENCY cycles (1..4), then
// returns the extended result over a valid/ready handshake.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN -- when defined, misaligned
// halfword/word loads take the error path and never touch the RAM.
module dmem_load_unit
  import dmem_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Req_valid,
  output logic              Req_ready,
  input  logic [ADDR_W-1:0] Req_addr,
  input  logic [2:0]        Req_funct3,
  output logic              Mem_re,
  output logic [ADDR_W-3:0] Mem_addr,
  input  logic [31:0]       Mem_rdata,
  output logic              Rsp_valid,
  input  logic              Rsp_ready,
  output logic [31:0]       Rsp_data,
  output logic              Rsp_err
);

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          funct3_q;
  logic [CNT_W-1:0]    cnt;
  logic [31:0]         rsp_data_q;
  logic                rsp_err_q;
  logic [31:0]         ext_data;
  logic                req_misaligned;
  logic                req_bad;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign req_misaligned = is_misaligned(Req_funct3, Req_addr[1:0]);
`else
  assign req_misaligned = 1'b0;
`endif

  // Requests that are answered with an error and no RAM access
  assign req_bad = is_illegal_funct3(Req_funct3) || req_misaligned;

  assign Mem_addr = addr_q[ADDR_W-1:2];
  assign Rsp_data = rsp_data_q;
  assign Rsp_err  = rsp_err_q;

  load_align_ext u_align (
    .word   (Mem_rdata),
    .offset (addr_q[1:0]),
    .funct3 (funct3_q),
    .result (ext_data)
  );

  // FSM state register
  always_ff @(posedge Clock) begin
    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and state-decoded handshake/strobe outputs
  always_comb begin
    state_next = state;
    Req_ready  = 1'b0;
    Mem_re     = 1'b0;
    Rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        Req_ready = 1'b1;
        if (Req_valid) state_next = req_bad ? RESP : ISSUE;
      end
      ISSUE: begin
        Mem_re     = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_next = RESP;
      end
      RESP: begin
        Rsp_valid = 1'b1;
        if (Rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, latency counter and response registers
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      addr_q     <= '0;
      funct3_q   <= '0;
      cnt        <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Req_valid) begin
            addr_q   <= Req_addr;
            funct3_q <= Req_funct3;
            if (req_bad) begin
              rsp_data_q <= '0;
              rsp_err_q  <= 1'b1;
            end
          end
        end
        ISSUE: cnt <= CNT_W'(READ_LATENCY - 1);
        WAIT: begin
          if (cnt == '0) begin
            rsp_data_q <= ext_data;
            rsp_err_q  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_load_unit.sv
// Directed bench for dmem_load_unit. Two instances share the request bus:
// index 0 runs with READ_LATENCY=1, index 1 with READ_LATENCY=3. A small
// RAM stand-in presents the real word only in the cycle it is due and
// filler data in every other cycle, so a mistimed sample shows up.
module tb_dmem_load_unit;
  import dmem_pkg::*;

  logic             Clock;
  logic             Reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [31:0]      req_addr;
  logic [2:0]       req_funct3;
  logic [1:0]       mem_re;
  logic [1:0][29:0] mem_addr;
  logic [1:0][31:0] mem_rdata;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [1:0][31:0] rsp_data;
  logic [1:0]       rsp_err;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] FILLER = 32'h5A5A_A5A5;

  dmem_load_unit #(.ADDR_W(32), .READ_LATENCY(1)) u_dut_l1 (
    .Clock(Clock), .Reset(Reset),
    .Req_valid(req_valid[0]), .Req_ready(req_ready[0]),
    .Req_addr(req_addr), .Req_funct3(req_funct3),
    .Mem_re(mem_re[0]), .Mem_addr(mem_addr[0]), .Mem_rdata(mem_rdata[0]),
    .Rsp_valid(rsp_valid[0]), .Rsp_ready(rsp_ready[0]),
    .Rsp_data(rsp_data[0]), .Rsp_err(rsp_err[0])
  );

  dmem_load_unit #(.ADDR_W(32), .READ_LATENCY(3)) u_dut_l3 (
    .Clock(Clock), .Reset(Reset),
    .Req_valid(req_valid[1]), .Req_ready(req_ready[1]),
    .Req_addr(req_addr), .Req_funct3(req_funct3),
    .Mem_re(mem_re[1]), .Mem_addr(mem_addr[1]), .Mem_rdata(mem_rdata[1]),
    .Rsp_valid(rsp_valid[1]), .Rsp_ready(rsp_ready[1]),
    .Rsp_data(rsp_data[1]), .Rsp_err(rsp_err[1])
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Runs one load on instance k with Rsp_ready held high and checks timing,
  // RAM strobe, word address, result and the return to IDLE.
  task automatic run_load(input int k, input logic [31:0] addr,
                          input logic [2:0] f3, input logic [31:0] word,
                          input logic [31:0] exp_data, input logic exp_err,
                          input string name);
    int          lat;
    int          exp_vcycle;
    int          re_cycle;
    int          re_count;
    int          vcycle;
    logic [29:0] re_addr;
    logic [31:0] got_data;
    logic        got_err;
    lat        = (k == 0) ? 1 : 3;
    exp_vcycle = exp_err ? 1 : 2 + lat;
    re_cycle   = -1;
    re_count   = 0;
    vcycle     = -1;
    re_addr    = '0;
    got_data   = 32'hxxxx_xxxx;
    got_err    = 1'bx;
    // cycle 0: present the request
    @(negedge Clock);
    checks++;
    if (req_ready[k] !== 1'b1) begin
      errors++;
      $display("FAIL %s req_ready_c0: got %b expected 1", name, req_ready[k]);
    end
    req_valid[k] = 1'b1;
    req_addr     = addr;
    req_funct3   = f3;
    rsp_ready[k] = 1'b1;
    mem_rdata[k] = FILLER;
    for (int c = 1; c <= 12 && vcycle < 0; c++) begin
      @(negedge Clock);
      req_valid[k] = 1'b0;
      req_addr     = 32'hFFFF_FFFF;
      req_funct3   = 3'b111;
      mem_rdata[k] = (c == 1 + lat) ? word : FILLER;
      if (mem_re[k] === 1'b1) begin
        re_count++;
        if (re_cycle < 0) begin
          re_cycle = c;
          re_addr  = mem_addr[k];
        end
      end
      if (rsp_valid[k] === 1'b1) begin
        vcycle   = c;
        got_data = rsp_data[k];
        got_err  = rsp_err[k];
      end
    end
    checks++;
    if (vcycle != exp_vcycle) begin
      errors++;
      $display("FAIL %s rsp_valid_cycle: got %0d expected %0d", name, vcycle, exp_vcycle);
    end
    checks++;
    if (got_data !== exp_data) begin
      errors++;
      $display("FAIL %s rsp_data: got %h expected %h", name, got_data, exp_data);
    end
    checks++;
    if (got_err !== exp_err) begin
      errors++;
      $display("FAIL %s rsp_err: got %b expected %b", name, got_err, exp_err);
    end
    checks++;
    if (re_count != (exp_err ? 0 : 1)) begin
      errors++;
      $display("FAIL %s mem_re_count: got %0d expected %0d", name, re_count, exp_err ? 0 : 1);
    end
    if (!exp_err) begin
      checks++;
      if (re_cycle != 1 || re_addr !== addr[31:2]) begin
        errors++;
        $display("FAIL %s mem_read: got cycle %0d addr %h expected cycle 1 addr %h",
                 name, re_cycle, re_addr, addr[31:2]);
      end
    end
    // handshake completed at the end of the response cycle
    @(negedge Clock);
    checks++;
    if (rsp_valid[k] !== 1'b0 || req_ready[k] !== 1'b1) begin
      errors++;
      $display("FAIL %s after_handshake: got valid %b ready %b expected valid 0 ready 1",
               name, rsp_valid[k], req_ready[k]);
    end
  endtask

  task automatic check_idle_outputs(input int k, input string name);
    checks++;
    if ({req_ready[k], mem_re[k], rsp_valid[k], rsp_err[k]} !== 4'b1000 ||
        rsp_data[k] !== 32'h0) begin
      errors++;
      $display("FAIL %s: got ready %b re %b valid %b err %b data %h expected 1 0 0 0 00000000",
               name, req_ready[k], mem_re[k], rsp_valid[k], rsp_err[k], rsp_data[k]);
    end
  endtask

  task automatic test_reset();
    Reset      = 1'b0;
    req_valid  = '0;
    rsp_ready  = '1;
    req_addr   = '0;
    req_funct3 = LW;
    mem_rdata  = {FILLER, FILLER};
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    check_idle_outputs(0, "reset_l1");
    check_idle_outputs(1, "reset_l3");
  endtask

  task automatic test_illegal_funct3();
    run_load(0, 32'h0000_0040, 3'b011, 32'h1111_2222, 32'h0, 1'b1, "illegal_011");
    run_load(0, 32'h0000_0044, 3'b111, 32'h1111_2222, 32'h0, 1'b1, "illegal_111");
  endtask

  task automatic test_byte_loads();
    run_load(0, 32'h0000_0103, LB,  32'h80FF_1234, 32'hFFFF_FF80, 1'b0, "lb_0x103");
    run_load(0, 32'h0000_0101, LBU, 32'h80FF_1234, 32'h0000_0012, 1'b0, "lbu_0x101");
    run_load(0, 32'h0000_0102, LB,  32'h80FF_1234, 32'hFFFF_FFFF, 1'b0, "lb_0x102");
    run_load(0, 32'h0000_0102, LBU, 32'h80FF_1234, 32'h0000_00FF, 1'b0, "lbu_0x102");
  endtask

  task automatic test_half_word_loads();
    run_load(0, 32'h0000_0102, LHU, 32'h8001_7FFF, 32'h0000_8001, 1'b0, "lhu_0x102");
    run_load(0, 32'h0000_0102, LH,  32'h8001_7FFF, 32'hFFFF_8001, 1'b0, "lh_0x102");
    run_load(0, 32'h0000_0100, LH,  32'h8001_7FFF, 32'h0000_7FFF, 1'b0, "lh_0x100");
    run_load(0, 32'h0000_0200, LW,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, "lw_0x200");
  endtask

  task automatic test_misaligned();
`ifdef DMEM_MISALIGN_TRAP_EN
    run_load(0, 32'h0000_0201, LW, 32'hDEAD_BEEF, 32'h0, 1'b1, "lw_0x201_trap");
    run_load(0, 32'h0000_0103, LH, 32'h8001_7FFF, 32'h0, 1'b1, "lh_0x103_trap");
`else
    run_load(0, 32'h0000_0201, LW, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, "lw_0x201");
    run_load(0, 32'h0000_0103, LH, 32'h8001_7FFF, 32'hFFFF_8001, 1'b0, "lh_0x103");
`endif
  endtask

  // Stall in RESP, reset while stalled, then a latency-3 load completes
  task automatic test_stall_reset();
    @(negedge Clock);
    req_valid[0] = 1'b1;
    req_addr     = 32'h0000_0010;
    req_funct3   = LW;
    rsp_ready[0] = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge Clock);
      req_valid[0] = 1'b0;
      mem_rdata[0] = (c == 2) ? 32'h1234_5678 : FILLER;
    end
    for (int s = 0; s < 5; s++) begin
      checks++;
      if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'h1234_5678 || rsp_err[0] !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got valid %b data %h err %b expected 1 12345678 0",
                 s, rsp_valid[0], rsp_data[0], rsp_err[0]);
      end
      @(negedge Clock);
    end
    Reset = 1'b0;
    @(negedge Clock);
    check_idle_outputs(0, "reset_in_resp");
    Reset        = 1'b1;
    rsp_ready[0] = 1'b1;
    run_load(1, 32'h0000_0300, LW, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, "lw_lat3");
    run_load(1, 32'h0000_0301, LBU, 32'hCAFE_F00D, 32'h0000_00F0, 1'b0, "lbu_lat3");
  endtask

  initial begin
    test_reset();
    test_illegal_funct3();
    test_byte_loads();
    test_half_word_loads();
    test_misaligned();
    test_stall_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
